rsa_link_master: RTL

Host-side initiator for the RSA accelerator's byte-serial register protocol. It converts parallel register-access requests into a command byte plus optional data byte on an Avalon-ST transmit stream feeding a UART, and collects the single response byte returned for reads. It sits either on a second FPGA driving the accelerator board over RS-232, or in loopback benches directly facing the accelerator's UART-side command decoder.

---
 rtl/rsa_link_pkg.sv | 29 ++
 rtl/rsa_link_timer.sv | 33 +++
 rtl/rsa_link_master.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/rsa_link_pkg.sv
// Shared types and constants for the RSA accelerator byte-serial register link master.
package rsa_link_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_CMD,
    S_SEND_DATA,
    S_WAIT_RSP,
    S_DONE
  } state_e;

  localparam int CMD_ADDR_BIT  = 0;
  localparam int CMD_WRITE_BIT = 1;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_RX_ERR  = 2'b01,
    ST_TIMEOUT = 2'b10
  } status_e;

  function automatic logic [7:0] make_cmd(input logic write, input logic addr);
    logic [7:0] cmd;
    cmd                = 8'h00;
    cmd[CMD_ADDR_BIT]  = addr;
    cmd[CMD_WRITE_BIT] = write;
    return cmd;
  endfunction

endpackage

// File: rtl/rsa_link_timer.sv
// Read-response watchdog: counts cycles while enabled and flags the terminal count.
module rsa_link_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign expired = (count_q == TERMINAL);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

endmodule

// File: rtl/rsa_link_master.sv
// Host-side initiator: register request -> command(+data) bytes on TX, one response byte from RX.
// Optional read-response timeout enabled by defining RSA_LINK_TIMEOUT_EN.
module rsa_link_master
  import rsa_link_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic       req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic [1:0] rsp_status,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_error,
  output logic       rx_ready,
  output logic [7:0] stray_cnt,
  output logic       busy
);

  state_e     state_q, state_d;
  status_e    status_q, status_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic [7:0] stray_q, stray_d;
  logic       live_q;
  logic       rx_accept;
  logic       timed_out;

`ifdef RSA_LINK_TIMEOUT_EN
  rsa_link_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_q != S_WAIT_RSP),
    .enable  (state_q == S_WAIT_RSP),
    .expired (timed_out)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_CYCLES, CNT_W};
  assign timed_out  = 1'b0;
`endif

  // live_q keeps both ready outputs low while reset is held and for the release edge.
  assign rx_ready   = live_q;
  assign rx_accept  = rx_valid && live_q;
  assign req_ready  = live_q && (state_q == S_IDLE);
  assign tx_valid   = (state_q == S_SEND_CMD) || (state_q == S_SEND_DATA);
  assign rsp_valid  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign rsp_data   = rsp_data_q;
  assign rsp_status = status_q;
  assign stray_cnt  = stray_q;

  always_comb begin
    tx_data = 8'h00;
    if (state_q == S_SEND_CMD)  tx_data = cmd_q;
    if (state_q == S_SEND_DATA) tx_data = wdata_q;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    cmd_d      = cmd_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    stray_d    = stray_q;

    if (rx_accept && (state_q != S_WAIT_RSP) && (stray_q != 8'hFF)) begin
      stray_d = stray_q + 8'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          cmd_d      = make_cmd(req_write, req_addr);
          wdata_d    = req_wdata;
          rsp_data_d = 8'h00;
          status_d   = ST_OK;
          state_d    = S_SEND_CMD;
        end
      end
      S_SEND_CMD: begin
        if (tx_ready) state_d = cmd_q[CMD_WRITE_BIT] ? S_SEND_DATA : S_WAIT_RSP;
      end
      S_SEND_DATA: begin
        if (tx_ready) state_d = S_DONE;
      end
      S_WAIT_RSP: begin
        // A beat in the terminal-count cycle takes priority over the timeout.
        if (rx_accept) begin
          rsp_data_d = rx_data;
          status_d   = rx_error ? ST_RX_ERR : ST_OK;
          state_d    = S_DONE;
        end else if (timed_out) begin
          rsp_data_d = 8'h00;
          status_d   = ST_TIMEOUT;
          state_d    = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      status_q   <= ST_OK;
      cmd_q      <= 8'h00;
      wdata_q    <= 8'h00;
      rsp_data_q <= 8'h00;
      stray_q    <= 8'h00;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      cmd_q      <= cmd_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      stray_q    <= stray_d;
      live_q     <= 1'b1;
    end
  end

endmodule
